// File: rtl/rnd_refill_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : rnd_refill_buffer
//  Brief    : FIFO buffer of PRNG randomness words feeding the masked AES core.
//             It primes to full before releasing words, and counts starved cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module rnd_refill_buffer #(
  parameter int RND   = 680,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [RND-1:0]               in_rnd,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [RND-1:0]               out_rnd,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [7:0]                   starve_cnt
);

  localparam int c_LVL_W = $clog2(DEPTH+1);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam logic [c_LVL_W-1:0] c_FULL    = c_LVL_W'(DEPTH);
  localparam logic [c_LVL_W-1:0] c_LVL_ONE = c_LVL_W'(1);
  localparam logic [c_PTR_W-1:0] c_LAST    = c_PTR_W'(DEPTH-1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

  typedef enum logic [0:0] {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t               r_state;
  logic [RND-1:0]       r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_LVL_W-1:0]   r_level;
  logic                 r_out_valid;
  logic [7:0]           r_starve_cnt;

  logic                 w_space;
  logic                 w_push;
  logic                 w_pop;
  logic [c_LVL_W-1:0]   w_level_nxt;

  function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] p);
    return (p == c_LAST) ? '0 : p + c_PTR_ONE;
  endfunction

  // nrst only gates the visible ready; the internal push needs no gating
  // because every register is held in reset anyway.
  assign w_space  = (r_level < c_FULL) && !flush;
  assign in_ready = nrst && w_space;
  assign w_push   = in_valid && w_space;
  assign w_pop    = r_out_valid && out_ready && !flush;

  always_comb begin
    w_level_nxt = r_level;
    if (flush)
      w_level_nxt = '0;
    else if (w_push && !w_pop)
      w_level_nxt = r_level + c_LVL_ONE;
    else if (!w_push && w_pop)
      w_level_nxt = r_level - c_LVL_ONE;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_rnd;
        r_wr_ptr        <= f_next_ptr(r_wr_ptr);
      end
      if (w_pop)
        r_rd_ptr <= f_next_ptr(r_rd_ptr);
      r_level <= w_level_nxt;
    end
  end

  // Release words only once the buffer has been filled completely, so the
  // core never stalls mid-encryption on a half-empty buffer.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= PRIME;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= PRIME;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        PRIME: begin
          if (w_level_nxt == c_FULL) begin
            r_state     <= RUN;
            r_out_valid <= 1'b1;
          end else begin
            r_out_valid <= 1'b0;
          end
        end
        RUN: begin
          if (w_level_nxt == '0) begin
            r_state     <= PRIME;
            r_out_valid <= 1'b0;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= PRIME;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      r_starve_cnt <= '0;
    else if (out_ready && !r_out_valid && !flush && (r_starve_cnt != 8'hFF))
      r_starve_cnt <= r_starve_cnt + 8'd1;
  end

  assign out_valid  = r_out_valid;
  assign out_rnd    = r_mem[r_rd_ptr];
  assign level      = r_level;
  assign starve_cnt = r_starve_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rnd_refill_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rnd_refill_buffer
//  Brief    : Drives DEPTH=2 and DEPTH=8 buffers with shared stimulus and
//             compares both against queue-based reference models.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rnd_refill_buffer;

  logic       clk = 1'b0;
  logic       nrst;
  logic       flush;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_rnd;

  logic       in_ready2, out_valid2;
  logic [7:0] out_rnd2, starve2;
  logic [1:0] level2;
  logic       in_ready8, out_valid8;
  logic [7:0] out_rnd8, starve8;
  logic [3:0] level8;

  rnd_refill_buffer #(.RND(8), .DEPTH(2)) u_dut2 (
    .clk(clk), .nrst(nrst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2), .in_rnd(in_rnd),
    .out_valid(out_valid2), .out_ready(out_ready), .out_rnd(out_rnd2),
    .level(level2), .starve_cnt(starve2)
  );

  rnd_refill_buffer #(.RND(8), .DEPTH(8)) u_dut8 (
    .clk(clk), .nrst(nrst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready8), .in_rnd(in_rnd),
    .out_valid(out_valid8), .out_ready(out_ready), .out_rnd(out_rnd8),
    .level(level8), .starve_cnt(starve8)
  );

  always #5 clk = ~clk;

  // Reference state: words held, whether words are being released, starve count.
  logic [7:0] q2[$];
  logic [7:0] q8[$];
  bit         run2, run8;
  int         st2, st8;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    q2.delete(); q8.delete();
    run2 = 1'b0; run8 = 1'b0;
    st2 = 0; st8 = 0;
  endtask

  task automatic check_outputs();
    bit ev2, ev8;
    ev2 = run2 && (q2.size() != 0);
    ev8 = run8 && (q8.size() != 0);
    check("level2",     32'(level2),     32'(q2.size()));
    check("out_valid2", 32'(out_valid2), 32'(ev2));
    check("starve2",    32'(starve2),    32'(st2));
    if (ev2) check("out_rnd2", 32'(out_rnd2), 32'(q2[0]));
    check("level8",     32'(level8),     32'(q8.size()));
    check("out_valid8", 32'(out_valid8), 32'(ev8));
    check("starve8",    32'(starve8),    32'(st8));
    if (ev8) check("out_rnd8", 32'(out_rnd8), 32'(q8[0]));
  endtask

  // One clock cycle: apply inputs, check ready, clock, advance models, check.
  task automatic step(input bit f, input bit iv, input logic [7:0] d, input bit ordy);
    bit ov2, ov8, ir2, ir8, push2, push8, pop2, pop8;
    flush = f; in_valid = iv; in_rnd = d; out_ready = ordy;
    ov2 = run2 && (q2.size() != 0);
    ov8 = run8 && (q8.size() != 0);
    ir2 = (q2.size() < 2) && !f;
    ir8 = (q8.size() < 8) && !f;
    push2 = iv && ir2;  pop2 = ov2 && ordy;
    push8 = iv && ir8;  pop8 = ov8 && ordy;
    #1;
    check("in_ready2", 32'(in_ready2), 32'(ir2));
    check("in_ready8", 32'(in_ready8), 32'(ir8));
    @(posedge clk);
    #1;
    if (ordy && !ov2 && !f && st2 < 255) st2++;
    if (ordy && !ov8 && !f && st8 < 255) st8++;
    if (f) begin
      q2.delete(); run2 = 1'b0;
      q8.delete(); run8 = 1'b0;
    end else begin
      if (pop2)  q2.delete(0);
      if (push2) q2.push_back(d);
      if (!run2 && q2.size() == 2) run2 = 1'b1;
      else if (run2 && q2.size() == 0) run2 = 1'b0;
      if (pop8)  q8.delete(0);
      if (push8) q8.push_back(d);
      if (!run8 && q8.size() == 8) run8 = 1'b1;
      else if (run8 && q8.size() == 0) run8 = 1'b0;
    end
    check_outputs();
  endtask

  initial begin
    int st_before;
    nrst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_rnd = 8'h00;
    reset_model();

    // Reset state held through a clock edge
    #12;
    check("rst_level2",    32'(level2),     32'd0);
    check("rst_out_valid2",32'(out_valid2), 32'd0);
    check("rst_in_ready2", 32'(in_ready2),  32'd0);
    check("rst_out_rnd2",  32'(out_rnd2),   32'd0);
    check("rst_starve2",   32'(starve2),    32'd0);
    check("rst_in_ready8", 32'(in_ready8),  32'd0);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    check("post_rst_in_ready2", 32'(in_ready2), 32'd1);

    // Priming: nothing released until full, then arrival order
    step(0, 1, 8'hA1, 1);
    step(0, 1, 8'hB2, 1);
    check("prime_head", 32'(out_rnd2), 32'hA1);
    // Full: push refused, contents intact
    step(0, 1, 8'hC3, 0);
    check("full_head", 32'(out_rnd2), 32'hA1);
    step(0, 0, 8'h00, 1);
    check("second_word", 32'(out_rnd2), 32'hB2);
    // Simultaneous push and pop at level 1
    step(0, 1, 8'hD4, 1);
    check("pushpop_head", 32'(out_rnd2), 32'hD4);
    // Drain then three starved cycles
    step(0, 1, 8'hE5, 0);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    st_before = st2;
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
    check("starve_delta3", 32'(starve2), 32'(st_before + 3));

    // Flush while pushing at level 1
    step(0, 1, 8'h11, 0);
    step(1, 1, 8'h22, 0);
    check("flush_level", 32'(level2), 32'd0);
    step(0, 1, 8'h33, 0);
    step(0, 1, 8'h44, 0);
    check("after_flush_head", 32'(out_rnd2), 32'h33);
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 300; i++) step(0, 0, 8'h00, 1);
    check("starve_sat2", 32'(starve2), 32'd255);

    // Asynchronous reset between edges at level 2
    step(0, 1, 8'h55, 0);
    step(0, 1, 8'h66, 0);
    #2;
    nrst = 1'b0;
    #1;
    reset_model();
    check("async_level2",     32'(level2),     32'd0);
    check("async_out_valid2", 32'(out_valid2), 32'd0);
    check("async_level8",     32'(level8),     32'd0);
    check("async_starve2",    32'(starve2),    32'd0);
    @(negedge clk);
    nrst = 1'b1;
    #1;

    // Randomised traffic, rare flushes
    for (int i = 0; i < 1000; i++)
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
           8'($urandom), 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
